// File: rtl/timer_pkg.sv
// Shared types and BCD digit limits for the MM:SS kitchen timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_UNIT     = 4'd9;
    localparam logic [2:0] BCD_MAX_SEC_TENS = 3'd5;

endpackage

// File: rtl/bcd_mmss_down.sv
// Four-digit BCD MM:SS down-counter with parallel load, one-second decrement and zero flag.
module bcd_mmss_down
    import timer_pkg::*;
(
    input  logic       CLK,
    input  logic       RES,
    input  logic       LOAD,
    input  logic       DEC,
    input  logic [3:0] LD_M_HI,
    input  logic [3:0] LD_M_LO,
    input  logic [2:0] LD_S_HI,
    input  logic [3:0] LD_S_LO,
    output logic [3:0] M_HI,
    output logic [3:0] M_LO,
    output logic [2:0] S_HI,
    output logic [3:0] S_LO,
    output logic       ZERO
);

    // Borrow ripples from seconds units up to minute tens; load wins over decrement.
    always_ff @(posedge CLK) begin
        if (RES) begin
            M_HI <= 4'd0;
            M_LO <= 4'd0;
            S_HI <= 3'd0;
            S_LO <= 4'd0;
        end else if (LOAD) begin
            M_HI <= LD_M_HI;
            M_LO <= LD_M_LO;
            S_HI <= LD_S_HI;
            S_LO <= LD_S_LO;
        end else if (DEC) begin
            if (S_LO != 4'd0) begin
                S_LO <= S_LO - 4'd1;
            end else begin
                S_LO <= BCD_MAX_UNIT;
                if (S_HI != 3'd0) begin
                    S_HI <= S_HI - 3'd1;
                end else begin
                    S_HI <= BCD_MAX_SEC_TENS;
                    if (M_LO != 4'd0) begin
                        M_LO <= M_LO - 4'd1;
                    end else begin
                        M_LO <= BCD_MAX_UNIT;
                        M_HI <= M_HI - 4'd1;
                    end
                end
            end
        end
    end

    assign ZERO = (M_HI == 4'd0) && (M_LO == 4'd0) && (S_HI == 3'd0) && (S_LO == 4'd0);

endmodule

// File: rtl/timer_run_ctrl.sv
// Kitchen timer mode controller: SET -> RUN -> (PAUSE) -> ALARM sequencing, buzzer and display select.
// Optional display blink during ALARM is enabled by defining ALARM_BLINK_EN.
module timer_run_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_SECS = 10,
    parameter int ALARM_CW   = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       SEC_PULSE,
    input  logic       HALF_SEC_PULSE,
    input  logic [3:0] SET_M_HI,
    input  logic [3:0] SET_M_LO,
    input  logic [2:0] SET_S_HI,
    input  logic [3:0] SET_S_LO,
    output logic       SET_ENABLE,
    output logic [3:0] DISP_M_HI,
    output logic [3:0] DISP_M_LO,
    output logic [2:0] DISP_S_HI,
    output logic [3:0] DISP_S_LO,
    output logic       BUZZER,
    output logic       DISP_BLANK,
    output logic [1:0] STATE
);

    localparam logic [ALARM_CW-1:0] ALARM_LOAD = ALARM_CW'(ALARM_SECS);
    localparam logic [ALARM_CW-1:0] CNT_ONE    = ALARM_CW'(1);

    state_t              state;
    logic [ALARM_CW-1:0] alarm_cnt;
    logic                buzzer_q;
    logic                blank_q;

    logic [3:0] cnt_m_hi;
    logic [3:0] cnt_m_lo;
    logic [2:0] cnt_s_hi;
    logic [3:0] cnt_s_lo;
    logic       cnt_zero;

    logic set_nonzero;
    logic at_one;
    logic start_load;
    logic dec_en;

    assign set_nonzero = (SET_M_HI != 4'd0) || (SET_M_LO != 4'd0) ||
                         (SET_S_HI != 3'd0) || (SET_S_LO != 4'd0);
    assign at_one      = (cnt_m_hi == 4'd0) && (cnt_m_lo == 4'd0) &&
                         (cnt_s_hi == 3'd0) && (cnt_s_lo == 4'd1);

    // CLEAR outranks START_STOP, which in turn suppresses a coincident second tick.
    assign start_load = (state == ST_SET) && !CLEAR && START_STOP && set_nonzero;
    assign dec_en     = (state == ST_RUN) && !CLEAR && !START_STOP && SEC_PULSE && !cnt_zero;

    bcd_mmss_down u_count (
        .CLK     (CLK),
        .RES     (RES),
        .LOAD    (start_load),
        .DEC     (dec_en),
        .LD_M_HI (SET_M_HI),
        .LD_M_LO (SET_M_LO),
        .LD_S_HI (SET_S_HI),
        .LD_S_LO (SET_S_LO),
        .M_HI    (cnt_m_hi),
        .M_LO    (cnt_m_lo),
        .S_HI    (cnt_s_hi),
        .S_LO    (cnt_s_lo),
        .ZERO    (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= ST_SET;
            alarm_cnt <= '0;
            buzzer_q  <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            case (state)
                ST_SET: begin
                    if (start_load) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (CLEAR) begin
                        state <= ST_SET;
                    end else if (START_STOP) begin
                        state <= ST_PAUSE;
                    end else if (SEC_PULSE && at_one) begin
                        state     <= ST_ALARM;
                        alarm_cnt <= ALARM_LOAD;
                        buzzer_q  <= 1'b1;
                        blank_q   <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (CLEAR) begin
                        state <= ST_SET;
                    end else if (START_STOP) begin
                        state <= ST_RUN;
                    end
                end
                ST_ALARM: begin
`ifdef ALARM_BLINK_EN
                    if (HALF_SEC_PULSE) begin
                        blank_q <= ~blank_q;
                    end
`endif
                    // Any exit from ALARM overrides the blink toggle above.
                    if (CLEAR || START_STOP) begin
                        state    <= ST_SET;
                        buzzer_q <= 1'b0;
                        blank_q  <= 1'b0;
                    end else if (SEC_PULSE) begin
                        if (alarm_cnt <= CNT_ONE) begin
                            state     <= ST_SET;
                            alarm_cnt <= '0;
                            buzzer_q  <= 1'b0;
                            blank_q   <= 1'b0;
                        end else begin
                            alarm_cnt <= alarm_cnt - CNT_ONE;
                        end
                    end
                end
                default: state <= ST_SET;
            endcase
        end
    end

`ifndef ALARM_BLINK_EN
    logic unused_half_sec;
    assign unused_half_sec = HALF_SEC_PULSE;
`endif

    assign STATE      = state;
    assign SET_ENABLE = (state == ST_SET);
    assign BUZZER     = buzzer_q;
    assign DISP_BLANK = blank_q;

    // In SET the user is editing, so show the live set value rather than the counter.
    assign DISP_M_HI = (state == ST_SET) ? SET_M_HI : cnt_m_hi;
    assign DISP_M_LO = (state == ST_SET) ? SET_M_LO : cnt_m_lo;
    assign DISP_S_HI = (state == ST_SET) ? SET_S_HI : cnt_s_hi;
    assign DISP_S_LO = (state == ST_SET) ? SET_S_LO : cnt_s_lo;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Bench for timer_run_ctrl: directed vector table, alarm/blink sequences and randomized run vs. a seconds-based model.
module tb_timer_run_ctrl;

    localparam int ALARM_SECS = 10;

    logic       CLK = 1'b0;
    logic       RES;
    logic       START_STOP;
    logic       CLEAR;
    logic       SEC_PULSE;
    logic       HALF_SEC_PULSE;
    logic [3:0] SET_M_HI;
    logic [3:0] SET_M_LO;
    logic [2:0] SET_S_HI;
    logic [3:0] SET_S_LO;
    logic       SET_ENABLE;
    logic [3:0] DISP_M_HI;
    logic [3:0] DISP_M_LO;
    logic [2:0] DISP_S_HI;
    logic [3:0] DISP_S_LO;
    logic       BUZZER;
    logic       DISP_BLANK;
    logic [1:0] STATE;

    timer_run_ctrl #(.ALARM_SECS(ALARM_SECS), .ALARM_CW(4)) dut (
        .CLK            (CLK),
        .RES            (RES),
        .START_STOP     (START_STOP),
        .CLEAR          (CLEAR),
        .SEC_PULSE      (SEC_PULSE),
        .HALF_SEC_PULSE (HALF_SEC_PULSE),
        .SET_M_HI       (SET_M_HI),
        .SET_M_LO       (SET_M_LO),
        .SET_S_HI       (SET_S_HI),
        .SET_S_LO       (SET_S_LO),
        .SET_ENABLE     (SET_ENABLE),
        .DISP_M_HI      (DISP_M_HI),
        .DISP_M_LO      (DISP_M_LO),
        .DISP_S_HI      (DISP_S_HI),
        .DISP_S_LO      (DISP_S_LO),
        .BUZZER         (BUZZER),
        .DISP_BLANK     (DISP_BLANK),
        .STATE          (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          res;
        bit          ss;
        bit          clr;
        bit          sec;
        logic [15:0] set_t;
        int          exp_state;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t tbl[$];
    int   vec_count   = 0;
    int   miscompares = 0;

    // Model: mode number plus remaining time as a plain count of seconds.
    int m_state = 0;
    int m_time  = 0;
    int m_acnt  = 0;
    bit m_blank = 1'b0;

    function automatic int set_secs();
        return (int'(SET_M_HI) * 10 + int'(SET_M_LO)) * 60 + int'(SET_S_HI) * 10 + int'(SET_S_LO);
    endfunction

    function automatic logic [15:0] model_disp();
        int m;
        int s;
        if (m_state == 0)
            return {SET_M_HI, SET_M_LO, 1'b0, SET_S_HI, SET_S_LO};
        m = m_time / 60;
        s = m_time % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step();
        int prev;
        prev = m_state;
        if (RES) begin
            m_state = 0;
            m_time  = 0;
            m_acnt  = 0;
        end else begin
            case (prev)
                0: if (!CLEAR && START_STOP && set_secs() != 0) begin
                       m_time  = set_secs();
                       m_state = 1;
                   end
                1: if (CLEAR) m_state = 0;
                   else if (START_STOP) m_state = 2;
                   else if (SEC_PULSE) begin
                       m_time = m_time - 1;
                       if (m_time == 0) begin
                           m_state = 3;
                           m_acnt  = ALARM_SECS;
                       end
                   end
                2: if (CLEAR) m_state = 0;
                   else if (START_STOP) m_state = 1;
                default: if (CLEAR || START_STOP) m_state = 0;
                   else if (SEC_PULSE) begin
                       m_acnt = m_acnt - 1;
                       if (m_acnt == 0) m_state = 0;
                   end
            endcase
        end
`ifdef ALARM_BLINK_EN
        if (prev == 3 && m_state == 3 && !RES && HALF_SEC_PULSE) m_blank = ~m_blank;
`endif
        if (m_state != 3) m_blank = 1'b0;
    endtask

    task automatic set_time(input logic [15:0] t);
        SET_M_HI = t[15:12];
        SET_M_LO = t[11:8];
        SET_S_HI = t[6:4];
        SET_S_LO = t[3:0];
    endtask

    task automatic release_pulses();
        RES            = 1'b0;
        START_STOP     = 1'b0;
        CLEAR          = 1'b0;
        SEC_PULSE      = 1'b0;
        HALF_SEC_PULSE = 1'b0;
    endtask

    task automatic check_output(input string name, input int exp_state,
                                input logic [15:0] exp_disp, input bit exp_blank);
        logic [15:0] got_disp;
        bit          exp_buz;
        bit          exp_sen;
        got_disp = {DISP_M_HI, DISP_M_LO, 1'b0, DISP_S_HI, DISP_S_LO};
        exp_buz  = (exp_state == 3);
        exp_sen  = (exp_state == 0);
        vec_count++;
        if (STATE !== 2'(exp_state) || BUZZER !== exp_buz || SET_ENABLE !== exp_sen ||
            got_disp !== exp_disp || DISP_BLANK !== exp_blank) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got state=%0d buz=%b sen=%b disp=%h blank=%b, want state=%0d buz=%b sen=%b disp=%h blank=%b",
                     name, $time, STATE, BUZZER, SET_ENABLE, got_disp, DISP_BLANK,
                     exp_state, exp_buz, exp_sen, exp_disp, exp_blank);
        end
    endtask

    // One clock edge: model follows the same inputs, outputs sampled 1 time unit later.
    task automatic apply_stimulus(input string name);
        @(posedge CLK);
        model_step();
        #1;
        check_output(name, m_state, model_disp(), m_blank);
    endtask

    task automatic add_row(input bit res, input bit ss, input bit clr, input bit sec,
                           input logic [15:0] t, input int st, input logic [15:0] d);
        vec_t v;
        v = '{res, ss, clr, sec, t, st, d};
        tbl.push_back(v);
    endtask

    initial begin
        bit exp_blink;
`ifdef ALARM_BLINK_EN
        exp_blink = 1'b1;
`else
        exp_blink = 1'b0;
`endif
        release_pulses();
        RES = 1'b1;
        set_time(16'h0000);

        add_row(1, 0, 0, 0, 16'h0003, 0, 16'h0003);
        add_row(0, 1, 0, 0, 16'h0003, 1, 16'h0003);
        add_row(0, 0, 0, 1, 16'h0003, 1, 16'h0002);
        add_row(0, 0, 0, 1, 16'h0003, 1, 16'h0001);
        add_row(0, 0, 0, 1, 16'h0003, 3, 16'h0000);
        add_row(0, 1, 0, 0, 16'h0003, 0, 16'h0003);
        add_row(0, 1, 0, 0, 16'h0100, 1, 16'h0100);
        add_row(0, 0, 0, 1, 16'h0100, 1, 16'h0059);
        add_row(0, 0, 1, 0, 16'h0100, 0, 16'h0100);
        add_row(0, 1, 0, 0, 16'h1000, 1, 16'h1000);
        add_row(0, 0, 0, 1, 16'h1000, 1, 16'h0959);
        add_row(0, 0, 1, 1, 16'h0030, 0, 16'h0030);
        add_row(0, 1, 0, 0, 16'h0030, 1, 16'h0030);
        add_row(0, 1, 0, 1, 16'h0030, 2, 16'h0030);
        add_row(0, 0, 0, 1, 16'h0030, 2, 16'h0030);
        add_row(0, 0, 0, 1, 16'h0030, 2, 16'h0030);
        add_row(0, 1, 0, 0, 16'h0030, 1, 16'h0030);
        add_row(0, 0, 0, 1, 16'h0030, 1, 16'h0029);
        add_row(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        add_row(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
        add_row(0, 1, 0, 0, 16'h0005, 1, 16'h0005);
        add_row(0, 1, 0, 0, 16'h0042, 2, 16'h0005);
        add_row(0, 0, 1, 0, 16'h0042, 0, 16'h0042);
        add_row(0, 1, 1, 0, 16'h0042, 0, 16'h0042);
        add_row(0, 1, 0, 0, 16'h0517, 1, 16'h0517);
        add_row(0, 0, 0, 1, 16'h0517, 1, 16'h0516);
        add_row(1, 0, 0, 1, 16'h0000, 0, 16'h0000);
        add_row(0, 1, 0, 0, 16'h0000, 0, 16'h0000);

        foreach (tbl[i]) begin
            RES        = tbl[i].res;
            START_STOP = tbl[i].ss;
            CLEAR      = tbl[i].clr;
            SEC_PULSE  = tbl[i].sec;
            set_time(tbl[i].set_t);
            apply_stimulus($sformatf("model_row%0d", i));
            check_output($sformatf("tbl_row%0d", i), tbl[i].exp_state, tbl[i].exp_disp, 1'b0);
            release_pulses();
        end

        // Full alarm timeout with half-second blinking between second ticks.
        set_time(16'h0001);
        START_STOP = 1'b1;
        apply_stimulus("alarm_start");
        release_pulses();
        SEC_PULSE = 1'b1;
        apply_stimulus("alarm_enter");
        check_output("alarm_enter_exp", 3, 16'h0000, 1'b0);
        release_pulses();
        for (int k = 1; k <= ALARM_SECS; k++) begin
            HALF_SEC_PULSE = 1'b1;
            apply_stimulus($sformatf("alarm_half%0d", k));
            check_output($sformatf("alarm_half%0d_exp", k), 3, 16'h0000, exp_blink);
            release_pulses();
            SEC_PULSE      = 1'b1;
            HALF_SEC_PULSE = 1'b1;
            apply_stimulus($sformatf("alarm_sec%0d", k));
            if (k < ALARM_SECS)
                check_output($sformatf("alarm_sec%0d_exp", k), 3, 16'h0000, 1'b0);
            else
                check_output("alarm_timeout_exp", 0, 16'h0001, 1'b0);
            release_pulses();
        end

        // Silencing the alarm with START_STOP.
        START_STOP = 1'b1;
        apply_stimulus("silence_start");
        release_pulses();
        SEC_PULSE = 1'b1;
        apply_stimulus("silence_enter");
        release_pulses();
        HALF_SEC_PULSE = 1'b1;
        apply_stimulus("silence_half");
        check_output("silence_half_exp", 3, 16'h0000, exp_blink);
        release_pulses();
        START_STOP = 1'b1;
        apply_stimulus("silence_ss");
        check_output("silence_ss_exp", 0, 16'h0001, 1'b0);
        release_pulses();

        // Randomized traffic; short set times make alarms frequent.
        for (int n = 0; n < 4000; n++) begin
            RES            = ($urandom_range(149) == 0);
            CLEAR          = ($urandom_range(24) == 0);
            START_STOP     = ($urandom_range(15) == 0);
            SEC_PULSE      = ($urandom_range(2) == 0);
            HALF_SEC_PULSE = ($urandom_range(1) == 0);
            if ($urandom_range(39) == 0) begin
                if ($urandom_range(1) == 0) begin
                    set_time({12'h000, 4'($urandom_range(5))});
                end else begin
                    SET_M_HI = 4'($urandom_range(9));
                    SET_M_LO = 4'($urandom_range(9));
                    SET_S_HI = 3'($urandom_range(5));
                    SET_S_LO = 4'($urandom_range(9));
                end
            end
            apply_stimulus($sformatf("rand%0d", n));
        end
        release_pulses();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
